// File: rtl/accel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_seq_pkg
// Description : Shared types and elaboration helpers for the accelerator
//               job sequencer (lane state encoding, clog2, round-robin math).
// Revision    : 1.0 - initial release
// ============================================================================
package accel_seq_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE   = 2'd0,
        LANE_RUN    = 2'd1,
        LANE_REPORT = 2'd2
    } lane_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits for a single lane.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int rr_dist(input int idx, input int base, input int n);
        return (idx >= base) ? (idx - base) : (idx + n - base);
    endfunction

endpackage
`default_nettype wire

// File: rtl/job_fifo.sv
`default_nettype none
// ============================================================================
// Module      : job_fifo
// Description : Synchronous FIFO with registered occupancy count; pointers
//               carry one extra wrap bit to tell full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module job_fifo
    import accel_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [clog2(DEPTH):0] count,
    output logic                  empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + PW'(do_push) - PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : accel_sequencer
// Description : Queues accelerator jobs and dispatches them round-robin to
//               N_LANES lanes; each lane stays active until its completion
//               report is consumed. Define ACCEL_SEQ_TIMEOUT_EN to add a
//               per-lane watchdog that reports hung jobs with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_sequencer
    import accel_seq_pkg::*;
#(
    parameter int N_LANES        = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int JOB_W          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          trigger_valid,
    output logic                          trigger_ready,
    input  logic [JOB_W-1:0]              trigger_job,
    output logic [N_LANES-1:0]            lane_active,
    output logic [N_LANES*JOB_W-1:0]      lane_job,
    input  logic [N_LANES-1:0]            lane_done,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [idx_width(N_LANES)-1:0] report_lane,
    output logic [JOB_W-1:0]              report_job,
    output logic                          report_error,
    output logic [clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                          busy
);

    localparam int LANE_W = idx_width(N_LANES);
    localparam int CNT_W  = clog2(QUEUE_DEPTH) + 1;

    if (N_LANES < 1 || N_LANES > 8) begin : g_bad_lanes
        $error("accel_sequencer: N_LANES must be in 1..8");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("accel_sequencer: QUEUE_DEPTH must be a power of 2, at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("accel_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [JOB_W-1:0]   fifo_head;
    logic [CNT_W-1:0]   count_next;

    lane_state_e        state_q [N_LANES];
    lane_state_e        state_d [N_LANES];
    logic [JOB_W-1:0]   job_q   [N_LANES];
    logic [JOB_W-1:0]   job_d   [N_LANES];
    logic [N_LANES-1:0] fresh_idle_q, fresh_idle_d;
    logic [N_LANES-1:0] lane_active_q, lane_active_d;
    logic [N_LANES-1:0] timeout_hit;
    logic [N_LANES-1:0] lane_err;

    logic               dispatch_en;
    logic [LANE_W-1:0]  dispatch_lane;
    logic [LANE_W-1:0]  disp_ptr_q, disp_ptr_d;
    logic [LANE_W-1:0]  rep_ptr_q, rep_ptr_d;
    int                 disp_best;
    int                 rep_best;

    logic               handshake;
    logic               report_valid_q, report_valid_d;
    logic [LANE_W-1:0]  report_lane_q, report_lane_d;
    logic [JOB_W-1:0]   report_job_q, report_job_d;
    logic               report_error_q, report_error_d;
    logic               busy_q, busy_d;

    job_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_job_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (trigger_job),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (queue_count),
        .empty     (fifo_empty)
    );

    // Full is judged from the registered count alone, so a pop cannot
    // open a slot for a push in the same cycle.
    assign trigger_ready = (queue_count != CNT_W'(QUEUE_DEPTH));
    assign fifo_push     = trigger_valid & trigger_ready;
    assign fifo_pop      = dispatch_en;
    assign handshake     = report_valid_q & report_ready;

    always_comb begin
        dispatch_en   = 1'b0;
        dispatch_lane = '0;
        disp_best     = N_LANES;
        for (int i = 0; i < N_LANES; i++) begin
            if (state_q[i] == LANE_IDLE && !fresh_idle_q[i] && !fifo_empty &&
                rr_dist(i, int'(disp_ptr_q), N_LANES) < disp_best) begin
                dispatch_en   = 1'b1;
                dispatch_lane = LANE_W'(i);
                disp_best     = rr_dist(i, int'(disp_ptr_q), N_LANES);
            end
        end
        disp_ptr_d = dispatch_en ? LANE_W'(rr_next(int'(dispatch_lane), N_LANES))
                                 : disp_ptr_q;
    end

    // fresh_idle holds a lane out of dispatch for the cycle after its
    // handshake, forcing a visible accelerator reset between jobs.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            state_d[i]      = state_q[i];
            job_d[i]        = job_q[i];
            fresh_idle_d[i] = 1'b0;
            case (state_q[i])
                LANE_IDLE: begin
                    if (dispatch_en && dispatch_lane == LANE_W'(i)) begin
                        state_d[i] = LANE_RUN;
                        job_d[i]   = fifo_head;
                    end
                end
                LANE_RUN: begin
                    if (lane_done[i] || timeout_hit[i]) begin
                        state_d[i] = LANE_REPORT;
                    end
                end
                LANE_REPORT: begin
                    if (handshake && report_lane_q == LANE_W'(i)) begin
                        state_d[i]      = LANE_IDLE;
                        fresh_idle_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = LANE_IDLE;
            endcase
            lane_active_d[i] = (state_d[i] != LANE_IDLE);
        end
    end

`ifdef ACCEL_SEQ_TIMEOUT_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]    wd_q [N_LANES];
    logic [WD_W-1:0]    wd_d [N_LANES];
    logic [N_LANES-1:0] err_q, err_d;

    for (genvar g = 0; g < N_LANES; g++) begin : g_wd_hit
        assign timeout_hit[g] = (state_q[g] == LANE_RUN) && !lane_done[g] &&
                                (wd_q[g] == WD_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            wd_d[i]  = wd_q[i];
            err_d[i] = err_q[i];
            if (state_q[i] == LANE_IDLE && state_d[i] == LANE_RUN) begin
                wd_d[i]  = '0;
                err_d[i] = 1'b0;
            end else if (state_q[i] == LANE_RUN) begin
                wd_d[i] = wd_q[i] + WD_W'(1);
                if (timeout_hit[i]) begin
                    err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                wd_q[i] <= '0;
            end
            err_q <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                wd_q[i] <= wd_d[i];
            end
            err_q <= err_d;
        end
    end

    assign lane_err = err_d;
`else
    assign timeout_hit = '0;
    assign lane_err    = '0;
`endif

    // Selection looks at next-state so a lane finishing this cycle can be
    // reported immediately; a held report is never re-arbitrated.
    always_comb begin
        report_valid_d = report_valid_q;
        report_lane_d  = report_lane_q;
        report_job_d   = report_job_q;
        report_error_d = report_error_q;
        rep_ptr_d      = rep_ptr_q;
        rep_best       = N_LANES;
        if (!report_valid_q || handshake) begin
            report_valid_d = 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                if (state_d[i] == LANE_REPORT &&
                    rr_dist(i, int'(rep_ptr_q), N_LANES) < rep_best) begin
                    rep_best       = rr_dist(i, int'(rep_ptr_q), N_LANES);
                    report_valid_d = 1'b1;
                    report_lane_d  = LANE_W'(i);
                    report_job_d   = job_q[i];
                    report_error_d = lane_err[i];
                    rep_ptr_d      = LANE_W'(rr_next(i, N_LANES));
                end
            end
        end
    end

    always_comb begin
        count_next = queue_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        busy_d     = (count_next != '0) || (lane_active_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                state_q[i] <= LANE_IDLE;
                job_q[i]   <= '0;
            end
            fresh_idle_q   <= '0;
            lane_active_q  <= '0;
            disp_ptr_q     <= '0;
            rep_ptr_q      <= '0;
            report_valid_q <= 1'b0;
            report_lane_q  <= '0;
            report_job_q   <= '0;
            report_error_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                state_q[i] <= state_d[i];
                job_q[i]   <= job_d[i];
            end
            fresh_idle_q   <= fresh_idle_d;
            lane_active_q  <= lane_active_d;
            disp_ptr_q     <= disp_ptr_d;
            rep_ptr_q      <= rep_ptr_d;
            report_valid_q <= report_valid_d;
            report_lane_q  <= report_lane_d;
            report_job_q   <= report_job_d;
            report_error_q <= report_error_d;
            busy_q         <= busy_d;
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane_job
        assign lane_job[g*JOB_W +: JOB_W] = job_q[g];
    end

    assign lane_active  = lane_active_q;
    assign report_valid = report_valid_q;
    assign report_lane  = report_lane_q;
    assign report_job   = report_job_q;
    assign report_error = report_error_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: doc/accel_sequencer.md
# accel_sequencer

Multi-lane job sequencer between the host command interface and a bank of convolution accelerators. It queues accelerator trigger requests and dispatches each job to an idle lane. Each lane is held active, with its accelerator out of reset, until the accelerator signals done and the completion report has been consumed downstream. It generalises the single-accelerator trigger/done latch to `N_LANES` lanes with a job queue and a reporting handshake.

## Interface
- `N_LANES`, default 2: number of accelerator lanes (1..8).
- `QUEUE_DEPTH`, default 4: trigger FIFO entries; must be a power of 2, at least 2.
- `JOB_W`, default 8: job tag width.
- `TIMEOUT_CYCLES`, default 65535: watchdog limit per job; used only with the timeout feature.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `trigger_valid` in 1: host requests a job.
- `trigger_ready` out 1: queue can accept.
- `trigger_job` in JOB_W: job tag.
- `lane_active` out N_LANES: per-lane enable. The accelerator reset is `~rst_n | ~lane_active[i]`.
- `lane_job` out N_LANES*JOB_W: tag of the job on each lane. Lane i occupies bits [i*JOB_W +: JOB_W].
- `lane_done` in N_LANES: per-lane accelerator done level.
- `report_valid` out 1: completion report available.
- `report_ready` in 1: downstream consumes the report.
- `report_lane` out clog2(N_LANES) (minimum 1 bit): lane index of the report.
- `report_job` out JOB_W: tag of the reported job.
- `report_error` out 1: job ended by watchdog.
- `queue_count` out clog2(QUEUE_DEPTH)+1: number of queued, not yet dispatched jobs.
- `busy` out 1: queue non-empty, or any lane not IDLE.

## Operation
- **Queue.**
  - A job is accepted on `trigger_valid & trigger_ready`.
  - `trigger_ready = (queue_count != QUEUE_DEPTH)`. It is based on the count only, so there is no same-cycle pass-through when full, even if a pop occurs in that cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - FIFO order is strict.
- **Lane FSM:** one per lane, states IDLE, RUN, REPORT.
  - IDLE -> RUN: the lane is selected for dispatch while the queue is non-empty. The head tag is latched into `lane_job`.
  - RUN -> REPORT: `lane_done` is high. With the timeout feature, the watchdog can also cause this transition.
  - REPORT -> IDLE: the report handshake for this lane completes.
  - `lane_active` is 1 in RUN and REPORT, so accelerator results persist until reported.
- **Dispatch.**
  - At most one dispatch per cycle.
  - The target is the first IDLE lane at or after the round-robin pointer. The pointer then advances to the chosen lane + 1, modulo N_LANES.
  - A lane that entered IDLE this cycle is not eligible. `lane_active` is therefore low for at least one full cycle between jobs, which guarantees an accelerator reset pulse.
- **Reporting.**
  - The report source is a round-robin choice among lanes in REPORT, using a pointer independent of the dispatch pointer.
  - Once `report_valid` is high, `report_lane`, `report_job` and `report_error` are stable until the handshake completes, and the chosen lane does not change.
- `lane_done` is ignored in IDLE and REPORT.
- **Reset.** While `rst_n = 0` at a clock edge:
  - the queue empties and all lanes go to IDLE;
  - both pointers go to 0;
  - all outputs go to 0, except `trigger_ready = 1`.
  - Reset mid-job abandons the job without a report.

## Timing
- Trigger accepted at edge k: `queue_count` increments after edge k, and the earliest dispatch is at edge k+1 (`lane_active` high after k+1).
- `lane_done` high before edge d: the lane is in REPORT after d, and `report_valid` is high after d, provided no other report is pending.
- Handshake at edge h: the lane is IDLE after h, and the earliest re-dispatch to that lane is edge h+2.
- Back-to-back reports: the next `report_valid` can be high in the cycle immediately after a handshake.
- All outputs are registered. There is no combinational path from any input to any output except `trigger_ready`, which depends only on `queue_count`.

## Configuration
- **`ACCEL_SEQ_TIMEOUT_EN` defined:**
  - Each lane has a watchdog counter, cleared on entry to RUN and incremented each cycle in RUN.
  - If the counter reaches `TIMEOUT_CYCLES` while `lane_done` is low, the lane moves to REPORT with error set.
  - `report_error` reflects the reported lane's error bit.
- **Not defined:** there are no counters, and `report_error` is tied to 0.

## Structure
- **Package `accel_seq_pkg`:**
  - lane state encoding: IDLE=2'd0, RUN=2'd1, REPORT=2'd2;
  - a clog2 function;
  - the round-robin next-index helper.
- **Sub-module `job_fifo`:**
  - synchronous FIFO, parameters `WIDTH` and `DEPTH`;
  - push/pop/count interface;
  - wrap-around pointers carrying one extra bit for full/empty.
- Lane FSMs, dispatch and report arbiters live in `accel_sequencer`.

## Test plan
1. **Single job, N_LANES=2.** Push tag 0x11 and pulse `lane_done[0]` 5 cycles later.
   - `lane_active` = 01 one cycle after accept.
   - `report_valid` with lane 0, job 0x11, error 0.
   - After `report_ready`, lane 0 returns to IDLE.
2. **Queue full.** Push 6 jobs with both lanes busy.
   - 2 jobs dispatch.
   - `queue_count` reaches 4 and `trigger_ready` drops to 0.
   - The 7th push is stalled until the first dispatch frees a slot.
3. **Simultaneous done on both lanes, `report_ready` held low for 3 cycles.**
   - The report holds lane 0 with stable tag.
   - After the handshake, the next cycle reports lane 1.
4. **Re-dispatch gap.** Queue non-empty with a report handshake at edge h.
   - That lane is not redispatched before edge h+2.
   - `lane_active` is low for at least 1 cycle.
5. **Reset mid-job.** Drive `rst_n` low for 1 cycle while lane 1 is in RUN and 2 jobs are queued.
   - All outputs are 0, `trigger_ready` = 1, `queue_count` = 0, and no report is produced.
6. **Watchdog, `ACCEL_SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=20.** `lane_done` is never raised.
   - A report with `report_error` = 1 appears 20 cycles after dispatch.
